// File: rtl/pll_reset_ctrl_pkg.sv
// Shared definitions for the SB_PLL40 reset sequencer: state encoding (also used by
// the top-level LED/debug decode) and the counter-width helper.
package pll_reset_ctrl_pkg;

  localparam int W_STATE = 2;

  typedef enum logic [W_STATE-1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // One down-counter serves every timed state, so it is sized for the longest interval.
  function automatic int ctr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_1bit.sv
// Multi-flop synchroniser for a single asynchronous level (the raw PLL LOCK).
module sync_1bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// SB_PLL40 reset sequencer: drives RESETB, qualifies LOCK, retries on timeout and holds
// sys_rst until lock is stable. Define PLL_RESET_CTRL_STATS_EN for loss/timeout counters.
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_async,
  input  logic               relock_req,
  output logic               pll_resetb,
  output logic               sys_rst,
  output logic               locked_stable,
  output logic [W_STATE-1:0] state
`ifdef PLL_RESET_CTRL_STATS_EN
  ,
  output logic [7:0]         loss_count,
  output logic [7:0]         timeout_count
`endif
);

  localparam int W_CTR = ctr_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [W_CTR-1:0] RESET_LOAD   = W_CTR'(RESET_CYCLES - 1);
  localparam logic [W_CTR-1:0] TIMEOUT_LOAD = W_CTR'(LOCK_TIMEOUT - 1);
  localparam logic [W_CTR-1:0] STABLE_LOAD  = W_CTR'(STABLE_CYCLES - 1);
  localparam logic [W_CTR-1:0] CTR_ONE      = W_CTR'(1);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [W_CTR-1:0] ctr_q, ctr_d;

  sync_1bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_async),
    .q   (lock_s)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (relock_req) begin
      state_d = PLL_RESET;
      ctr_d   = RESET_LOAD;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (ctr_q == '0) begin
            state_d = WAIT_LOCK;
            ctr_d   = TIMEOUT_LOAD;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            ctr_d   = STABLE_LOAD;
          end else if (ctr_q == '0) begin
            state_d = PLL_RESET;
            ctr_d   = RESET_LOAD;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        STABLE: begin
          // Any drop in lock restarts qualification without disturbing the PLL.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            ctr_d   = TIMEOUT_LOAD;
          end else if (ctr_q == '0) begin
            state_d = RUN;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = PLL_RESET;
            ctr_d   = RESET_LOAD;
          end
        end
        default: begin
          state_d = PLL_RESET;
          ctr_d   = RESET_LOAD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLL_RESET;
      ctr_q         <= RESET_LOAD;
      pll_resetb    <= 1'b0;
      sys_rst       <= 1'b1;
      locked_stable <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      pll_resetb    <= (state_d != PLL_RESET);
      sys_rst       <= (state_d != RUN);
      locked_stable <= (state_d == RUN);
    end
  end

  assign state = state_q;

`ifdef PLL_RESET_CTRL_STATS_EN
  logic lock_lost, timed_out;

  // relock_req pre-empts both events, so forced relocks are never counted.
  assign lock_lost = !relock_req && (state_q == RUN) && !lock_s;
  assign timed_out = !relock_req && (state_q == WAIT_LOCK) && !lock_s && (ctr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_count    <= 8'd0;
      timeout_count <= 8'd0;
    end else begin
      if (lock_lost && (loss_count != 8'hFF))    loss_count    <= loss_count + 8'd1;
      if (timed_out && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed bring-up/fault scenarios plus random lock traffic,
// compared every cycle against a phase/elapsed-time model of the sequencer.
module tb_pll_reset_ctrl;

  localparam int RC = 4;
  localparam int LT = 64;
  localparam int SC = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock_async = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_resetb, sys_rst, locked_stable;
  logic [1:0] state;
`ifdef PLL_RESET_CTRL_STATS_EN
  logic [7:0] loss_count, timeout_count;
`endif

  pll_reset_ctrl #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock_async (pll_lock_async),
    .relock_req     (relock_req),
    .pll_resetb     (pll_resetb),
    .sys_rst        (sys_rst),
    .locked_stable  (locked_stable),
    .state          (state)
`ifdef PLL_RESET_CTRL_STATS_EN
    ,
    .loss_count     (loss_count),
    .timeout_count  (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: current phase plus the cycle on which it was entered; each phase
  // ends after a fixed number of elapsed cycles or on a lock event.
  int          m_phase = 0;
  longint      m_entry = 0;
  longint      cyc     = 0;
  bit [SS-1:0] m_hist  = '0;
  int          m_loss  = 0;
  int          m_tmo   = 0;
  bit          m_valid = 1'b0;

  task automatic enter(input int p);
    m_phase = p;
    m_entry = cyc;
  endtask

  task automatic model_step(input bit r, input bit rl, input bit a);
    bit     ls;
    longint spent;
    ls = m_hist[SS-1];
    if (r) begin
      enter(0);
      m_hist  = '0;
      m_loss  = 0;
      m_tmo   = 0;
      m_valid = 1'b1;
    end else begin
      m_hist = {m_hist[SS-2:0], a};
      spent  = cyc - m_entry;
      if (rl) enter(0);
      else begin
        case (m_phase)
          0: if (spent == RC) enter(1);
          1: begin
            if (ls) enter(2);
            else if (spent == LT) begin
              enter(0);
              if (m_tmo < 255) m_tmo++;
            end
          end
          2: begin
            if (!ls) enter(1);
            else if (spent == SC) enter(3);
          end
          default: begin
            if (!ls) begin
              enter(0);
              if (m_loss < 255) m_loss++;
            end
          end
        endcase
      end
    end
    cyc++;
  endtask

  // Single compare process: inputs change only on negedges, so posedge sampling is clean.
  initial begin
    bit r_s, rl_s, a_s;
    forever begin
      @(posedge clk);
      r_s  = rst;
      rl_s = relock_req;
      a_s  = pll_lock_async;
      model_step(r_s, rl_s, a_s);
      #1;
      if (m_valid) begin
        check("state", {30'd0, state}, m_phase);
        check("pll_resetb", {31'd0, pll_resetb}, {31'd0, m_phase != 0});
        check("sys_rst", {31'd0, sys_rst}, {31'd0, m_phase != 3});
        check("locked_stable", {31'd0, locked_stable}, {31'd0, m_phase == 3});
`ifdef PLL_RESET_CTRL_STATS_EN
        check("loss_count", {24'd0, loss_count}, m_loss);
        check("timeout_count", {24'd0, timeout_count}, m_tmo);
`endif
      end
    end
  end

  bit       track = 1'b0;
  int       seq[$];

  initial begin
    forever begin
      @(negedge clk);
      if (track && (seq.size() == 0 || seq[$] != int'(state))) seq.push_back(int'(state));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int i;
    i = 0;
    while (state !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (state !== s) check({name, " wait expired"}, {30'd0, state}, {30'd0, s});
  endtask

  // Counts consecutive negedges (including the current one) with pll_resetb at level.
  task automatic measure_resetb(input logic level, output int n);
    n = 0;
    while (pll_resetb === level && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int loss0, tmo0;
    bit saw_wait, resetb_low;
    int hold;

    // Reset state
    cycles(2);
    check("reset state", {30'd0, state}, 0);
    check("reset pll_resetb", {31'd0, pll_resetb}, 0);
    check("reset sys_rst", {31'd0, sys_rst}, 1);
    check("reset locked_stable", {31'd0, locked_stable}, 0);

    // Nominal bring-up: lock arrives 10 cycles after RESETB releases
    rst   = 1'b0;
    track = 1'b1;
    measure_resetb(1'b0, n);
    check("bringup resetb low cycles", n, 4);
    cycles(10);
    pll_lock_async = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    track = 1'b0;
    check("async lock to sys_rst release", n, 19);
    check("bringup in RUN", {30'd0, state}, 3);
    check("bringup locked_stable", {31'd0, locked_stable}, 1);
    check("state sequence length", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) check("state sequence entry", seq[i], i);

    // Lock loss in RUN
    pll_lock_async = 1'b0;
    n = 0;
    while (sys_rst === 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("loss to sys_rst", n, 3);
    check("loss pll_resetb", {31'd0, pll_resetb}, 0);
    check("loss state", {30'd0, state}, 0);
`ifdef PLL_RESET_CTRL_STATS_EN
    check("loss_count after first loss", {24'd0, loss_count}, 1);
`endif

    // Lock never asserts: periodic RESETB pulses
    measure_resetb(1'b0, n);
`ifdef PLL_RESET_CTRL_STATS_EN
    tmo0 = int'(timeout_count);
`endif
    measure_resetb(1'b1, n);
    check("wait_lock window", n, 64);
    measure_resetb(1'b0, n);
    check("retry resetb low cycles", n, 4);
`ifdef PLL_RESET_CTRL_STATS_EN
    check("timeout_count step", {24'd0, timeout_count}, tmo0 + 1);
`endif
    measure_resetb(1'b1, n);
    check("second wait_lock window", n, 64);
    check("no lock sys_rst held", {31'd0, sys_rst}, 1);
    wait_state(2'd1, 20, "retry wait_lock");

    // One-cycle lock glitch in STABLE
    pll_lock_async = 1'b1;
    wait_state(2'd2, 20, "reach stable");
    cycles(7);
    pll_lock_async = 1'b0;
    @(negedge clk);
    pll_lock_async = 1'b1;
    saw_wait = 1'b0;
    resetb_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state === 2'd1) saw_wait = 1'b1;
      if (pll_resetb !== 1'b1) resetb_low = 1'b1;
    end
    check("glitch back to wait_lock", {31'd0, saw_wait}, 1);
    check("glitch no resetb pulse", {31'd0, resetb_low}, 0);
    check("glitch reaches RUN", {30'd0, state}, 3);

    // relock_req coinciding with lock_s falling in RUN
`ifdef PLL_RESET_CTRL_STATS_EN
    loss0 = int'(loss_count);
`else
    loss0 = 0;
`endif
    pll_lock_async = 1'b0;
    cycles(2);
    relock_req = 1'b1;
    @(negedge clk);
    relock_req = 1'b0;
    check("relock state", {30'd0, state}, 0);
    measure_resetb(1'b0, n);
    check("relock resetb low cycles", n, 4);
`ifdef PLL_RESET_CTRL_STATS_EN
    check("relock not counted as loss", {24'd0, loss_count}, loss0);
`endif

    // rst for one cycle while in STABLE
    pll_lock_async = 1'b1;
    wait_state(2'd2, 100, "stable before rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst state", {30'd0, state}, 0);
    check("mid rst pll_resetb", {31'd0, pll_resetb}, 0);
    check("mid rst sys_rst", {31'd0, sys_rst}, 1);
`ifdef PLL_RESET_CTRL_STATS_EN
    check("mid rst loss_count", {24'd0, loss_count}, 0);
    check("mid rst timeout_count", {24'd0, timeout_count}, 0);
`endif

    // Random lock traffic with occasional relock requests and resets
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_lock_async = ~pll_lock_async;
        hold = pll_lock_async ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 80));
      end
      hold--;
      relock_req = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    relock_req = 1'b0;
    rst        = 1'b0;

    // 300 lock losses: loss_count saturates
    for (int k = 0; k < 300; k++) begin
      pll_lock_async = 1'b1;
      n = 0;
      while (sys_rst !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (sys_rst !== 1'b0) check("relock for loss loop", {31'd0, sys_rst}, 0);
      pll_lock_async = 1'b0;
      cycles(4);
    end
`ifdef PLL_RESET_CTRL_STATS_EN
    check("loss_count saturated", {24'd0, loss_count}, 255);
`endif
    check("after losses sys_rst", {31'd0, sys_rst}, 1);

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
